mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DAT_WIDTH, default 32, data width.
REQ-003 SHALL have parameter MAX_D_STREAK, default 4, range 1..7: the maximum number of consecutive data grants allowed while a fetch request waits.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports as follows.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req_i  input  1  fetch request.
- if_addr_i  input  ADDR_WIDTH  fetch address.
- if_rdata_o  output  DAT_WIDTH  fetch read data.
- if_valid_o  output  1  fetch transaction complete.
- dm_req_i  input  1  data request.
- dm_we_i  input  1  data write enable (1 = store, 0 = load).
- dm_addr_i  input  ADDR_WIDTH  data address.
- dm_wdata_i  input  DAT_WIDTH  store data.
- dm_rdata_o  output  DAT_WIDTH  load data.
- dm_valid_o  output  1  data transaction complete.
- mem_req_o  output  1  request to the shared memory.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_wdata_o  output  DAT_WIDTH  memory write data.
- mem_rdata_i  input  DAT_WIDTH  memory read data, valid with mem_ack_i.
- mem_ack_i  input  1  memory completes the current access.
- stall_o  output  1  pipeline stall.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, I_BUSY, D_BUSY.
REQ-006 In IDLE, the FSM SHALL sample requests at the clock edge:
- only if_req_i -> I_BUSY.
- only dm_req_i -> D_BUSY.
- both -> D_BUSY, unless the streak counter equals MAX_D_STREAK, in which case -> I_BUSY.
- neither -> stay in IDLE.
REQ-007 On entering a BUSY state, the arbiter SHALL latch the granted requester's address (and, for D, dm_we_i and dm_wdata_i) into registers that drive mem_addr_o, mem_we_o and mem_wdata_o.
REQ-008 Requester inputs SHALL be ignored while BUSY.
REQ-009 mem_req_o SHALL equal 1 exactly while in I_BUSY or D_BUSY; mem_we_o SHALL be 0 in I_BUSY.
REQ-010 In a BUSY state with mem_ack_i=1, the arbiter SHALL assert the granted requester's valid_o combinationally in that same cycle and return to IDLE at the next edge.
REQ-011 With mem_ack_i=0, the FSM SHALL remain BUSY with no timeout.
REQ-012 if_rdata_o and dm_rdata_o SHALL be driven by mem_rdata_i continuously; they are meaningful only while the matching valid_o is 1.
REQ-013 dm_valid_o SHALL also pulse for stores, as a completion signal.
REQ-014 Minimum latency: request sampled in IDLE at cycle 0, mem_req_o=1 in cycle 1, valid_o in cycle 1 if acked, IDLE in cycle 2; peak throughput is one access per 2 cycles.
REQ-015 A request still high when the FSM is back in IDLE SHALL be treated as a new transaction.
REQ-016 Deasserting a request while BUSY SHALL NOT abort the access; the valid_o pulse still occurs.
REQ-017 Streak counter (3 bits):
- increments on each D grant made while if_req_i=1, saturating at MAX_D_STREAK.
- clears to 0 on any I grant.
- clears to 0 on a D grant made while if_req_i=0.
REQ-018 stall_o SHALL equal (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o), combinational.
REQ-019 valid_o SHALL never be asserted in IDLE, even if mem_ack_i=1 there.

Reset
REQ-020 While rst_n=0, the arbiter SHALL asynchronously hold:
- FSM in IDLE and streak counter at 0.
- mem_req_o=0, mem_we_o=0.
- mem_addr_o=0, mem_wdata_o=0.
- if_valid_o=0, dm_valid_o=0.
REQ-021 Reset asserted mid-access SHALL drop mem_req_o immediately and emit no valid_o pulse for the in-flight access.

Verification
REQ-022 Fetch only: if_req_i=1, if_addr_i=0x100, mem acks 1 cycle after mem_req_o rises, mem_rdata_i=0x00500093 -> if_valid_o=1 for one cycle with if_rdata_o=0x00500093, mem_we_o=0.
REQ-023 Collision: if_req_i=dm_req_i=1 in IDLE, dm_we_i=1, dm_addr_i=0x2000, dm_wdata_i=0xDEADBEEF -> D_BUSY first with mem_we_o=1, mem_addr_o=0x2000, mem_wdata_o=0xDEADBEEF; I is served next; stall_o=1 until if_valid_o.
REQ-024 Starvation: both requests held continuously, single-cycle ack, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,...
REQ-025 Slow memory: mem_ack_i withheld for 5 cycles -> mem_req_o and mem_addr_o stable for all 5 cycles, one valid_o pulse on the ack cycle.
REQ-026 Reset in D_BUSY: rst_n pulled low before ack -> mem_req_o=0 at once, dm_valid_o never asserted, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and data) in front of one shared
// memory port. One access is in flight at a time. Data accesses normally win
// a collision, but a fetch that has waited through MAX_D_STREAK data grants
// is given the next slot.
//
// Handshake: a requester holds its req high; it is sampled only in IDLE. The
// granted access is presented on mem_* with mem_req_o=1 until mem_ack_i=1.
// In that cycle the requester's valid_o pulses combinationally, the read data
// is mem_rdata_i, and the arbiter returns to IDLE on the next edge.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DAT_WIDTH    = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DAT_WIDTH-1:0]  if_rdata_o,
    output logic                  if_valid_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DAT_WIDTH-1:0]  dm_wdata_i,
    output logic [DAT_WIDTH-1:0]  dm_rdata_o,
    output logic                  dm_valid_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DAT_WIDTH-1:0]  mem_wdata_o,
    input  logic [DAT_WIDTH-1:0]  mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stall_o
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic [2:0] MAX_S = 3'(MAX_D_STREAK);

    state_t                state, state_nxt;
    logic [2:0]            streak, streak_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  we_q, we_nxt;
    logic [DAT_WIDTH-1:0]  wdata_q, wdata_nxt;

    // State, streak counter and latched access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            streak  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    // Arbitration in IDLE, completion detection in the busy states.
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        addr_nxt   = addr_q;
        we_nxt     = we_q;
        wdata_nxt  = wdata_q;
        if_valid_o = 1'b0;
        dm_valid_o = 1'b0;
        case (state)
            IDLE: begin
                // A waiting fetch preempts data only once the streak is full.
                if (dm_req_i && !(if_req_i && streak == MAX_S)) begin
                    state_nxt = D_BUSY;
                    addr_nxt  = dm_addr_i;
                    we_nxt    = dm_we_i;
                    wdata_nxt = dm_wdata_i;
                    if (if_req_i) begin
                        streak_nxt = (streak >= MAX_S) ? MAX_S : streak + 3'd1;
                    end else begin
                        streak_nxt = '0;
                    end
                end else if (if_req_i) begin
                    state_nxt  = I_BUSY;
                    addr_nxt   = if_addr_i;
                    we_nxt     = 1'b0;
                    streak_nxt = '0;
                end
            end
            I_BUSY: begin
                if (mem_ack_i) begin
                    if_valid_o = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            D_BUSY: begin
                if (mem_ack_i) begin
                    dm_valid_o = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req_o   = (state != IDLE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;
    assign stall_o     = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o);

endmodule
